// File: rtl/trap_sequencer.sv
// trap_sequencer: queues guest I/O, tick and IRQ trap events and
// sequences NMI entry, supervisor ownership and return-to-guest.
//
// Ports: clk, reset (sync, active-high); virtual_enable; guest bus
// (io_cycle, io_is_write, io_port, io_data, m1_cycle); irq_sys_req,
// tick; supervisor sup_pop/sup_ack; head_* view of the oldest event,
// fifo_count, fifo_overflow; trap_state, nmi_n, capture_address, irq_n.
// Optional macro TRAP_TIMEOUT_EN adds a TRAPPED watchdog (TIMEOUT).
module trap_sequencer #(
  parameter int DEPTH     = 4,
  parameter int NMI_PULSE = 4,
  parameter int TIMEOUT   = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       virtual_enable,
  input  logic                       io_cycle,
  input  logic                       io_is_write,
  input  logic [7:0]                 io_port,
  input  logic [7:0]                 io_data,
  input  logic                       m1_cycle,
  input  logic                       irq_sys_req,
  input  logic                       tick,
  input  logic                       sup_pop,
  input  logic                       sup_ack,
  output logic [1:0]                 head_cause,
  output logic [7:0]                 head_port,
  output logic [7:0]                 head_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       fifo_overflow,
  output logic                       trap_state,
  output logic                       nmi_n,
  output logic                       capture_address,
  output logic                       irq_n
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(NMI_PULSE+1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PEND = 3'd1;
  localparam logic [2:0] S_NMI  = 3'd2;
  localparam logic [2:0] S_TRAP = 3'd3;
  localparam logic [2:0] S_RET  = 3'd4;

  logic [2:0]    state;
  logic          io_prev;
  logic          irq_prev;
  logic          m1_prev;
  logic          irq_lat;
  logic          tick_lat;
  logic [PW-1:0] nmi_cnt;

  logic [1:0]    mem_cause [DEPTH];
  logic [7:0]    mem_port  [DEPTH];
  logic [7:0]    mem_data  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic       win;
  logic       en;
  logic       flush;
  logic       m1_rise;
  logic       io_ev;
  logic       irq_c;
  logic       tick_c;
  logic       push;
  logic       empty;
  logic       full;
  logic       pop_ok;
  logic       wr_ok;
  logic       drop;
  logic       ack_ok;
  logic       wd_fire;
  logic [1:0] push_cause;
  logic [7:0] push_port;
  logic [7:0] push_data;

  assign win     = (state == S_IDLE) || (state == S_PEND);
  assign en      = win && virtual_enable;
  assign flush   = win && !virtual_enable;
  assign m1_rise = m1_cycle && !m1_prev;

  // Events that lose the one-push-per-cycle arbitration stay latched.
  assign io_ev  = en && io_cycle && !io_prev;
  assign irq_c  = en && ((irq_sys_req && !irq_prev) || irq_lat);
  assign tick_c = en && (tick || tick_lat);
  assign push   = io_ev || irq_c || tick_c;

  assign empty  = (fifo_count == '0);
  assign full   = (fifo_count == CW'(DEPTH));
  assign pop_ok = sup_pop && !empty;
  assign wr_ok  = push && (!full || pop_ok);
  assign drop   = push && full && !pop_ok;
  assign ack_ok = (state == S_TRAP) && sup_ack && empty;

  always_comb begin
    push_cause = 2'b10;
    push_port  = '0;
    push_data  = '0;
    if (io_ev) begin
      push_cause = {1'b0, io_is_write};
      push_port  = io_port;
      push_data  = io_data;
    end else if (irq_c) begin
      push_cause = 2'b11;
    end
  end

  assign head_cause = empty ? 2'b00 : mem_cause[rd_ptr];
  assign head_port  = empty ? 8'h00 : mem_port[rd_ptr];
  assign head_data  = empty ? 8'h00 : mem_data[rd_ptr];

  assign trap_state      = !win;
  assign nmi_n           = (state != S_NMI);
  assign capture_address = io_ev && wr_ok;

`ifdef TRAP_TIMEOUT_EN
  logic [15:0] wd;

  assign wd_fire = (state == S_TRAP) && !ack_ok &&
                   (wd == 16'(TIMEOUT-1));

  always_ff @(posedge clk) begin
    if (reset || state != S_TRAP) wd <= '0;
    else                          wd <= wd + 16'd1;
  end
`else
  logic unused_timeout;

  assign wd_fire        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_cause[wr_ptr] <= push_cause;
      mem_port[wr_ptr]  <= push_port;
      mem_data[wr_ptr]  <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      io_prev       <= 1'b0;
      irq_prev      <= 1'b0;
      m1_prev       <= 1'b0;
      irq_lat       <= 1'b0;
      tick_lat      <= 1'b0;
      nmi_cnt       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      fifo_overflow <= 1'b0;
      irq_n         <= 1'b1;
    end else begin
      io_prev  <= io_cycle;
      irq_prev <= irq_sys_req;
      m1_prev  <= m1_cycle;
      irq_n    <= trap_state ? 1'b1 : !irq_sys_req;

      if (drop || wd_fire) fifo_overflow <= 1'b1;

      if (flush || wd_fire) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + CW'(wr_ok) - CW'(pop_ok);
      end

      // Ticks seen while the supervisor owns the CPU wait for IDLE.
      if (en) begin
        irq_lat  <= irq_c && io_ev;
        tick_lat <= tick_c && (io_ev || irq_c);
      end else if (flush) begin
        irq_lat  <= 1'b0;
        tick_lat <= 1'b0;
      end else begin
        tick_lat <= tick_lat || tick;
      end

      unique case (state)
        S_IDLE: begin
          if (en && push) state <= S_PEND;
        end
        S_PEND: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (m1_rise) begin
            state   <= S_NMI;
            nmi_cnt <= '0;
          end
        end
        S_NMI: begin
          if (nmi_cnt == PW'(NMI_PULSE-1)) state <= S_TRAP;
          else nmi_cnt <= nmi_cnt + 1'b1;
        end
        S_TRAP: begin
          if (ack_ok || wd_fire) state <= S_RET;
        end
        S_RET: begin
          if (m1_rise) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: vector table, directed trap sequences and a
// randomized run against a queue-based behavioural model.
module tb_trap_sequencer;

  localparam int DEPTH     = 4;
  localparam int NMI_PULSE = 4;
  localparam int TIMEOUT   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       virtual_enable = 1'b0;
  logic       io_cycle = 1'b0;
  logic       io_is_write = 1'b0;
  logic [7:0] io_port = 8'h00;
  logic [7:0] io_data = 8'h00;
  logic       m1_cycle = 1'b0;
  logic       irq_sys_req = 1'b0;
  logic       tick = 1'b0;
  logic       sup_pop = 1'b0;
  logic       sup_ack = 1'b0;
  logic [1:0] head_cause;
  logic [7:0] head_port;
  logic [7:0] head_data;
  logic [2:0] fifo_count;
  logic       fifo_overflow;
  logic       trap_state;
  logic       nmi_n;
  logic       capture_address;
  logic       irq_n;

  trap_sequencer #(
    .DEPTH(DEPTH),
    .NMI_PULSE(NMI_PULSE),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .virtual_enable(virtual_enable),
    .io_cycle(io_cycle),
    .io_is_write(io_is_write),
    .io_port(io_port),
    .io_data(io_data),
    .m1_cycle(m1_cycle),
    .irq_sys_req(irq_sys_req),
    .tick(tick),
    .sup_pop(sup_pop),
    .sup_ack(sup_ack),
    .head_cause(head_cause),
    .head_port(head_port),
    .head_data(head_data),
    .fifo_count(fifo_count),
    .fifo_overflow(fifo_overflow),
    .trap_state(trap_state),
    .nmi_n(nmi_n),
    .capture_address(capture_address),
    .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    virtual_enable = 1'b0;
    io_cycle       = 1'b0;
    io_is_write    = 1'b0;
    io_port        = 8'h00;
    io_data        = 8'h00;
    m1_cycle       = 1'b0;
    irq_sys_req    = 1'b0;
    tick           = 1'b0;
    sup_pop        = 1'b0;
    sup_ack        = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic io_pulse(input logic w, input logic [7:0] p,
                          input logic [7:0] d);
    io_is_write = w;
    io_port     = p;
    io_data     = d;
    io_cycle    = 1'b1;
    cyc();
    io_cycle = 1'b0;
    cyc();
  endtask

  task automatic m1_rise();
    m1_cycle = 1'b1;
    cyc();
    m1_cycle = 1'b0;
  endtask

  task automatic count_nmi(output int n);
    n = 0;
    for (int g = 0; g < 32 && nmi_n == 1'b0; g++) begin
      n++;
      cyc();
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [1:0] c;
    logic [7:0] p;
    logic [7:0] d;
  } ev_t;

  ev_t q[$];
  bit  m_ovf, m_armed, m_owned, m_ret;
  bit  m_tick_hold, m_irq_hold, m_irq_n;
  bit  p_io, p_irq, p_m1;
  int  m_nmi_left, m_wd;

  function automatic bit m_trap();
    return (m_nmi_left > 0) || m_owned || m_ret;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_armed = 0; m_owned = 0; m_ret = 0;
    m_tick_hold = 0; m_irq_hold = 0; m_irq_n = 1;
    p_io = 0; p_irq = 0; p_m1 = 0;
    m_nmi_left = 0; m_wd = 0;
  endtask

  task automatic model_eval(output bit io_e, output bit irq_e,
                            output bit tk_e, output ev_t e,
                            output bit cap);
    bit open;
    open  = !m_trap() && virtual_enable;
    io_e  = open && io_cycle && !p_io;
    irq_e = open && ((irq_sys_req && !p_irq) || m_irq_hold);
    tk_e  = open && (tick || m_tick_hold);
    e.c = 2'b10; e.p = 8'h00; e.d = 8'h00;
    if (io_e) begin
      e.c = {1'b0, io_is_write}; e.p = io_port; e.d = io_data;
    end else if (irq_e) begin
      e.c = 2'b11;
    end
    cap = io_e && (q.size() < DEPTH || (sup_pop && q.size() > 0));
  endtask

  task automatic model_step();
    bit  io_e, irq_e, tk_e, cap, tr, m1r, psh;
    ev_t e;
    int  sz;
    model_eval(io_e, irq_e, tk_e, e, cap);
    tr  = m_trap();
    m1r = m1_cycle && !p_m1;
    sz  = q.size();
    psh = io_e || irq_e || tk_e;
    if (sup_pop && sz > 0) void'(q.pop_front());
    if (!tr) begin
      if (!virtual_enable) begin
        q.delete();
        m_armed = 0; m_tick_hold = 0; m_irq_hold = 0;
      end else begin
        if (psh) begin
          if (q.size() < DEPTH) q.push_back(e);
          else m_ovf = 1;
        end
        m_irq_hold  = irq_e && io_e;
        m_tick_hold = tk_e && (io_e || irq_e);
        if (m_armed && m1r) begin
          m_armed = 0;
          m_nmi_left = NMI_PULSE;
        end else if (psh) begin
          m_armed = 1;
        end
      end
    end else begin
      m_tick_hold = m_tick_hold || tick;
      if (m_nmi_left > 0) begin
        m_nmi_left--;
        if (m_nmi_left == 0) begin m_owned = 1; m_wd = 0; end
      end else if (m_owned) begin
        if (sup_ack && sz == 0) begin
          m_owned = 0; m_ret = 1;
        end
`ifdef TRAP_TIMEOUT_EN
        else begin
          m_wd++;
          if (m_wd == TIMEOUT) begin
            m_owned = 0; m_ret = 1; q.delete(); m_ovf = 1;
          end
        end
`endif
      end else if (m_ret && m1r) begin
        m_ret = 0;
      end
    end
    m_irq_n = tr ? 1'b1 : !irq_sys_req;
    p_io  = io_cycle;
    p_irq = irq_sys_req;
    p_m1  = m1_cycle;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       ve;
    logic       wr;
    logic [7:0] port;
    logic [7:0] data;
    logic       cap;
    logic [2:0] cnt;
    logic [1:0] cause;
    logic [7:0] hport;
    logic [7:0] hdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int  n;
    bit  io_e, irq_e, tk_e, cap;
    ev_t e, hd;
    logic [31:0] act, exp;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 3'd1, 2'b00, 8'h00, 8'hFF};
    vecs[1] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 3'd1, 2'b01, 8'hFF, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 8'h80, 8'h3C, 1'b1, 3'd1, 2'b01, 8'h80, 8'h3C};
    vecs[3] = '{1'b0, 1'b1, 8'h41, 8'h5A, 1'b0, 3'd0, 2'b00, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'h7E, 8'hC3, 1'b1, 3'd1, 2'b00, 8'h7E, 8'hC3};

    // Reset values and the basic OUT trap
    do_reset();
    check("rst count", 32'(fifo_count), 0);
    check("rst ovf", 32'(fifo_overflow), 0);
    check("rst head", {head_cause, head_port, head_data}, 0);
    check("rst trap", 32'(trap_state), 0);
    check("rst nmi_n", 32'(nmi_n), 1);
    check("rst cap", 32'(capture_address), 0);
    check("rst irq_n", 32'(irq_n), 1);

    virtual_enable = 1'b1;
    cyc();
    io_is_write = 1'b1; io_port = 8'h41; io_data = 8'h5A;
    io_cycle = 1'b1;
    #1;
    check("out cap", 32'(capture_address), 1);
    cyc();
    check("out count", 32'(fifo_count), 1);
    check("out cause", 32'(head_cause), 1);
    check("out port", 32'(head_port), 32'h41);
    check("out data", 32'(head_data), 32'h5A);
    check("out cap end", 32'(capture_address), 0);
    io_cycle = 1'b0;
    m1_rise();
    check("nmi trap", 32'(trap_state), 1);
    count_nmi(n);
    check("nmi width", n, NMI_PULSE);
    check("trapped", 32'(trap_state), 1);

    // Ack with entries pending is ignored; pop then ack returns
    sup_ack = 1'b1; cyc(); sup_ack = 1'b0; cyc();
    check("ack ign count", 32'(fifo_count), 1);
    check("ack ign trap", 32'(trap_state), 1);
    m1_rise(); cyc();
    check("ack ign m1", 32'(trap_state), 1);
    sup_pop = 1'b1; cyc(); sup_pop = 1'b0;
    check("pop count", 32'(fifo_count), 0);
    check("pop head", {head_cause, head_port, head_data}, 0);
    sup_ack = 1'b1; cyc(); sup_ack = 1'b0;
    irq_sys_req = 1'b1; cyc(); cyc();
    check("ret trap", 32'(trap_state), 1);
    check("ret irq_n", 32'(irq_n), 1);
    m1_rise();
    check("ret done", 32'(trap_state), 0);
    check("ret irq_n lag", 32'(irq_n), 1);
    cyc();
    check("irq steer on", 32'(irq_n), 0);
    check("no irq push", 32'(fifo_count), 0);
    irq_sys_req = 1'b0; cyc();
    check("irq steer off", 32'(irq_n), 1);

    // Table-driven single I/O captures
    foreach (vecs[i]) begin
      do_reset();
      virtual_enable = vecs[i].ve;
      cyc();
      io_is_write = vecs[i].wr;
      io_port = vecs[i].port;
      io_data = vecs[i].data;
      io_cycle = 1'b1;
      #1;
      check($sformatf("vec%0d cap", i), 32'(capture_address),
            32'(vecs[i].cap));
      cyc();
      io_cycle = 1'b0;
      check($sformatf("vec%0d cnt", i), 32'(fifo_count),
            32'(vecs[i].cnt));
      check($sformatf("vec%0d head", i),
            {head_cause, head_port, head_data},
            {vecs[i].cause, vecs[i].hport, vecs[i].hdata});
    end

    // I/O and tick together: I/O first, tick next
    do_reset();
    virtual_enable = 1'b1;
    cyc();
    io_is_write = 1'b0; io_port = 8'h10; io_data = 8'h22;
    io_cycle = 1'b1; tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    io_cycle = 1'b0;
    check("prio count", 32'(fifo_count), 2);
    check("prio head io", {head_cause, head_port, head_data}, 32'h01022);
    sup_pop = 1'b1; cyc(); sup_pop = 1'b0;
    check("prio count2", 32'(fifo_count), 1);
    check("prio head tick", {head_cause, head_port, head_data},
          32'h20000);

    // Overflow and pop+push while full
    do_reset();
    virtual_enable = 1'b1;
    cyc();
    for (int i = 0; i < DEPTH + 1; i++) io_pulse(1'b1, 8'(i), 8'(8'hA0 + i));
    check("ovf count", 32'(fifo_count), DEPTH);
    check("ovf flag", 32'(fifo_overflow), 1);
    check("ovf head", 32'(head_port), 0);
    io_port = 8'h05; io_cycle = 1'b1; sup_pop = 1'b1;
    #1;
    check("full cap", 32'(capture_address), 1);
    cyc();
    sup_pop = 1'b0; io_cycle = 1'b0;
    check("full pp count", 32'(fifo_count), DEPTH);
    check("full pp head", 32'(head_port), 1);
    check("ovf sticky", 32'(fifo_overflow), 1);

    // Tick during TRAPPED waits for IDLE, then re-traps
    do_reset();
    virtual_enable = 1'b1;
    cyc();
    io_pulse(1'b0, 8'h33, 8'h44);
    m1_rise();
    count_nmi(n);
    sup_pop = 1'b1; cyc(); sup_pop = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    check("tick held", 32'(fifo_count), 0);
    sup_ack = 1'b1; cyc(); sup_ack = 1'b0; cyc();
    check("tick held ret", 32'(fifo_count), 0);
    m1_rise();
    check("tick idle", 32'(trap_state), 0);
    cyc();
    check("tick pushed", 32'(fifo_count), 1);
    check("tick cause", 32'(head_cause), 2);
    m1_rise();
    check("retrap nmi", 32'(nmi_n), 0);
    cyc();
    reset = 1'b1; cyc();
    check("mid nmi rst nmi_n", 32'(nmi_n), 1);
    check("mid nmi rst trap", 32'(trap_state), 0);
    check("mid nmi rst count", 32'(fifo_count), 0);
    reset = 1'b0;

`ifdef TRAP_TIMEOUT_EN
    do_reset();
    virtual_enable = 1'b1;
    cyc();
    io_pulse(1'b1, 8'h77, 8'h01);
    m1_rise();
    count_nmi(n);
    for (int i = 0; i < TIMEOUT - 1; i++) cyc();
    check("wd before", 32'(fifo_count), 1);
    cyc();
    check("wd flush", 32'(fifo_count), 0);
    check("wd ovf", 32'(fifo_overflow), 1);
    check("wd ret trap", 32'(trap_state), 1);
    m1_rise();
    check("wd idle", 32'(trap_state), 0);
`endif

    // Randomized run against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      virtual_enable = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 3) == 0) io_cycle = !io_cycle;
      io_is_write = 1'($urandom_range(0, 1));
      io_port = 8'($urandom);
      io_data = 8'($urandom);
      if ($urandom_range(0, 2) == 0) m1_cycle = !m1_cycle;
      if ($urandom_range(0, 11) == 0) irq_sys_req = !irq_sys_req;
      tick = ($urandom_range(0, 7) == 0);
      sup_pop = (i < 1500) ? ($urandom_range(0, 7) == 0)
                           : ($urandom_range(0, 2) == 0);
      sup_ack = ($urandom_range(0, 4) == 0);
      #1;
      model_eval(io_e, irq_e, tk_e, e, cap);
      hd = (q.size() > 0) ? q[0] : '0;
      exp = 32'({3'(q.size()), hd.c, hd.p, hd.d, m_ovf, m_trap(),
                 !(m_nmi_left > 0), m_irq_n, cap});
      act = 32'({fifo_count, head_cause, head_port, head_data,
                 fifo_overflow, trap_state, nmi_n, irq_n,
                 capture_address});
      check($sformatf("rand cyc %0d", i), act, exp);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
